rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_pkg.sv | 15 +
 rtl/rf_wb_slot.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 111 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back arbiter.
// XLEN is taken from the `XLEN macro normally set by arvi_defines.vh; it falls back to 32 when that macro is not defined.
`ifndef XLEN
`define XLEN 32
`endif

package rf_wb_pkg;
    localparam int XLEN = `XLEN;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_slot.sv
// One-entry result buffer. It can refill on the same edge it drains, and it
// completes the handshake for x0 writes without storing them.
module rf_wb_slot
    import rf_wb_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rstn,
    input  logic    i_valid,
    input  wb_req_t i_req,
    input  logic    i_grant,
    output logic    o_ready,
    output logic    o_full,
    output logic    o_fill,
    output wb_req_t o_req
);
    logic    full_q, full_d;
    wb_req_t req_q, req_d;

    always_comb begin
        o_ready = !full_q || i_grant;
        o_fill  = i_valid && o_ready && (i_req.rd != REG_ZERO);
        full_d  = full_q;
        req_d   = req_q;
        if (o_fill) begin
            full_d = 1'b1;
            req_d  = i_req;
        end else if (i_grant) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign o_full = full_q;
    assign o_req  = req_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Oldest-first write-back arbiter from the EX and LD result slots to the single register-file write port.
// Defining RF_WB_BYPASS_EN makes the write being committed visible on the read outputs.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN = rf_wb_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_ex_valid,
    output logic            o_ex_ready,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    output logic            o_Wen,
    output logic [4:0]      o_Wnum,
    output logic [XLEN-1:0] o_Wd,
    input  logic [4:0]      i_Rnum1,
    input  logic [4:0]      i_Rnum2,
    input  logic [XLEN-1:0] i_Rd1,
    input  logic [XLEN-1:0] i_Rd2,
    output logic [XLEN-1:0] o_Rd1,
    output logic [XLEN-1:0] o_Rd2,
    output logic            o_busy
);
    wb_req_t ex_in, ld_in, ex_req, ld_req;
    logic    ex_full, ld_full, ex_fill, ld_fill;
    logic    grant_ex, grant_ld;
    logic    ex_older_q, ex_older_d;
    logic    wen_q, wen_d;
    logic [4:0]      wnum_q, wnum_d;
    logic [XLEN-1:0] wd_q, wd_d;

    always_comb begin
        ex_in.rd   = i_ex_rd;
        ex_in.data = i_ex_data;
        ld_in.rd   = i_ld_rd;
        ld_in.data = i_ld_data;
    end

    rf_wb_slot u_ex_slot (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_ex_valid), .i_req(ex_in),
        .i_grant(grant_ex), .o_ready(o_ex_ready), .o_full(ex_full),
        .o_fill(ex_fill), .o_req(ex_req)
    );

    rf_wb_slot u_ld_slot (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_ld_valid), .i_req(ld_in),
        .i_grant(grant_ld), .o_ready(o_ld_ready), .o_full(ld_full),
        .o_fill(ld_fill), .o_req(ld_req)
    );

    assign grant_ex = ex_full && (!ld_full || ex_older_q);
    assign grant_ld = ld_full && (!ex_full || !ex_older_q);

    // A slot that fills behind a waiting entry is the younger one, so the waiting side becomes older.
    always_comb begin
        ex_older_d = ex_older_q;
        if (ex_fill && ld_fill)
            ex_older_d = 1'b0;
        else if (ld_fill && ex_full && !grant_ex)
            ex_older_d = 1'b1;
        else if (ex_fill && ld_full && !grant_ld)
            ex_older_d = 1'b0;
    end

    always_comb begin
        wen_d  = grant_ex || grant_ld;
        wnum_d = wnum_q;
        wd_d   = wd_q;
        if (grant_ex) begin
            wnum_d = ex_req.rd;
            wd_d   = ex_req.data;
        end else if (grant_ld) begin
            wnum_d = ld_req.rd;
            wd_d   = ld_req.data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ex_older_q <= 1'b0;
            wen_q      <= 1'b0;
            wnum_q     <= '0;
            wd_q       <= '0;
        end else begin
            ex_older_q <= ex_older_d;
            wen_q      <= wen_d;
            wnum_q     <= wnum_d;
            wd_q       <= wd_d;
        end
    end

    assign o_Wen  = wen_q;
    assign o_Wnum = wnum_q;
    assign o_Wd   = wd_q;
    assign o_busy = ex_full || ld_full || wen_q;

`ifdef RF_WB_BYPASS_EN
    assign o_Rd1 = (wen_q && wnum_q == i_Rnum1 && i_Rnum1 != REG_ZERO) ? wd_q : i_Rd1;
    assign o_Rd2 = (wen_q && wnum_q == i_Rnum2 && i_Rnum2 != REG_ZERO) ? wd_q : i_Rd2;
`else
    logic unused_rnum;
    assign unused_rnum = ^{i_Rnum1, i_Rnum2};
    assign o_Rd1 = i_Rd1;
    assign o_Rd2 = i_Rd2;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: an arrival-order model is checked every cycle, with literal spot checks alongside.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic            i_clk = 1'b0;
    logic            i_rstn = 1'b0;
    logic            i_ex_valid = 1'b0, i_ld_valid = 1'b0;
    logic [4:0]      i_ex_rd = '0, i_ld_rd = '0, i_Rnum1 = '0, i_Rnum2 = '0;
    logic [XLEN-1:0] i_ex_data = '0, i_ld_data = '0, i_Rd1 = '0, i_Rd2 = '0;
    logic            o_ex_ready, o_ld_ready, o_Wen, o_busy;
    logic [4:0]      o_Wnum;
    logic [XLEN-1:0] o_Wd, o_Rd1, o_Rd2;

    rf_wb_arbiter dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready), .i_ex_rd(i_ex_rd), .i_ex_data(i_ex_data),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
        .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd),
        .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
        .o_Rd1(o_Rd1), .o_Rd2(o_Rd2), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: each stored result carries an arrival number; the smallest pending number is written next.
    logic            m_ex_v = 0, m_ld_v = 0;
    logic [4:0]      m_ex_rd = 0, m_ld_rd = 0;
    logic [XLEN-1:0] m_ex_d = 0, m_ld_d = 0;
    int              m_ex_seq = 0, m_ld_seq = 0, m_seq = 0;
    logic            m_wen = 0;
    logic [4:0]      m_wnum = 0;
    logic [XLEN-1:0] m_wd = 0;
    logic [XLEN-1:0] m_rf [32];

    function automatic int m_pick();
        if (m_ex_v && m_ld_v) return (m_ex_seq < m_ld_seq) ? 1 : 2;
        if (m_ex_v) return 1;
        if (m_ld_v) return 2;
        return 0;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        forever begin
            @(posedge i_clk or negedge i_rstn);
            if (!i_rstn) begin
                m_ex_v = 0; m_ld_v = 0; m_wen = 0; m_wnum = 0; m_wd = 0;
            end else begin
                int  g;
                logic er, lr;
                g  = m_pick();
                er = !m_ex_v || g == 1;
                lr = !m_ld_v || g == 2;
                m_wen = (g != 0);
                if (g == 1) begin m_wnum = m_ex_rd; m_wd = m_ex_d; m_ex_v = 0; end
                if (g == 2) begin m_wnum = m_ld_rd; m_wd = m_ld_d; m_ld_v = 0; end
                if (g != 0) m_rf[m_wnum] = m_wd;
                if (i_ld_valid && lr && i_ld_rd != 0) begin
                    m_ld_v = 1; m_ld_rd = i_ld_rd; m_ld_d = i_ld_data; m_ld_seq = m_seq++;
                end
                if (i_ex_valid && er && i_ex_rd != 0) begin
                    m_ex_v = 1; m_ex_rd = i_ex_rd; m_ex_d = i_ex_data; m_ex_seq = m_seq++;
                end
            end
        end
    end

    int  dut_writes = 0;
    logic win = 0;

    initial forever begin
        int g;
        logic [XLEN-1:0] e1, e2;
        @(negedge i_clk);
        g = m_pick();
        e1 = i_Rd1;
        e2 = i_Rd2;
`ifdef RF_WB_BYPASS_EN
        if (m_wen && m_wnum == i_Rnum1 && i_Rnum1 != 0) e1 = m_wd;
        if (m_wen && m_wnum == i_Rnum2 && i_Rnum2 != 0) e2 = m_wd;
`endif
        chk("ex_ready", o_ex_ready, !m_ex_v || g == 1);
        chk("ld_ready", o_ld_ready, !m_ld_v || g == 2);
        chk("wen", o_Wen, m_wen);
        chk("wnum", o_Wnum, m_wnum);
        chk("wd", o_Wd, m_wd);
        chk("busy", o_busy, m_ex_v || m_ld_v || m_wen);
        chk("rd1", o_Rd1, e1);
        chk("rd2", o_Rd2, e2);
        if (win && o_Wen) dut_writes++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    localparam logic [XLEN-1:0] BYP_EXP =
`ifdef RF_WB_BYPASS_EN
        'h55;
`else
        'h11;
`endif

    int stim_acc;
    logic [XLEN-1:0] mr3;

    initial begin
        // reset state
        #2;
        chk("rst_wen", o_Wen, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ex_ready", o_ex_ready, 1);
        chk("rst_ld_ready", o_ld_ready, 1);
        tick(); tick();
        i_rstn = 1'b1;
        tick();

        // EX only, rd=5
        i_ex_valid = 1; i_ex_rd = 5; i_ex_data = 'hDEADBEEF;
        tick();
        i_ex_valid = 0;
        chk("t1_ex_ready", o_ex_ready, 1);
        chk("t1_wen_early", o_Wen, 0);
        tick();
        chk("t1_wen", o_Wen, 1);
        chk("t1_wnum", o_Wnum, 5);
        chk("t1_wd", o_Wd, 'hDEADBEEF);
        chk("t1_ex_ready2", o_ex_ready, 1);
        tick(); tick();

        // LD to x0 is swallowed
        i_ld_valid = 1; i_ld_rd = 0; i_ld_data = 'h1234;
        chk("t2_ld_ready", o_ld_ready, 1);
        tick();
        i_ld_valid = 0;
        chk("t2_busy", o_busy, 0);
        tick();
        chk("t2_wen", o_Wen, 0);
        chk("t2_busy2", o_busy, 0);

        // same rd from both: LD first, EX last
        i_ex_valid = 1; i_ex_rd = 3; i_ex_data = 'hB;
        i_ld_valid = 1; i_ld_rd = 3; i_ld_data = 'hA;
        tick();
        i_ex_valid = 0; i_ld_valid = 0;
        tick();
        chk("t3_first_wd", o_Wd, 'hA);
        chk("t3_first_wen", o_Wen, 1);
        tick();
        chk("t3_second_wd", o_Wd, 'hB);
        chk("t3_second_wnum", o_Wnum, 3);
        mr3 = m_rf[3];
        chk("t3_model_x3", mr3, 'hB);
        tick(); tick();

        // continuous streaming from both sources
        stim_acc = 0;
        win = 1;
        i_ex_valid = 1; i_ex_rd = 10; i_ex_data = 'h1000;
        i_ld_valid = 1; i_ld_rd = 20; i_ld_data = 'h2000;
        for (int c = 0; c < 20; c++) begin
            logic er, lr;
            er = o_ex_ready;
            lr = o_ld_ready;
            tick();
            if (er) begin stim_acc++; i_ex_data = i_ex_data + 1; end
            if (lr) begin stim_acc++; i_ld_data = i_ld_data + 1; end
        end
        i_ex_valid = 0; i_ld_valid = 0;
        for (int c = 0; c < 5; c++) tick();
        win = 0;
        chk("t4_accepts", stim_acc, 21);
        chk("t4_no_loss", dut_writes, stim_acc);

        // reset with both slots full
        i_ex_valid = 1; i_ex_rd = 12; i_ex_data = 'hC;
        i_ld_valid = 1; i_ld_rd = 13; i_ld_data = 'hD;
        tick();
        i_ex_valid = 0; i_ld_valid = 0;
        chk("t5_busy_before", o_busy, 1);
        i_rstn = 0;
        #1;
        chk("t5_wen_in_rst", o_Wen, 0);
        chk("t5_ex_ready_in_rst", o_ex_ready, 1);
        chk("t5_ld_ready_in_rst", o_ld_ready, 1);
        tick(); tick();
        i_rstn = 1;
        dut_writes = 0;
        win = 1;
        for (int c = 0; c < 4; c++) tick();
        win = 0;
        chk("t5_no_writes", dut_writes, 0);
        chk("t5_busy_after", o_busy, 0);

        // read-port forwarding
        i_ex_valid = 1; i_ex_rd = 7; i_ex_data = 'h55;
        tick();
        i_ex_valid = 0;
        i_Rnum1 = 7; i_Rd1 = 'h11; i_Rnum2 = 0; i_Rd2 = 'h22;
        tick();
        chk("t6_wen", o_Wen, 1);
        chk("t6_rd1", o_Rd1, BYP_EXP);
        chk("t6_rd2", o_Rd2, 'h22);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
